// File: rtl/scan_pkg.sv
// Shared types and default sizing for the parameterised scan-chain block.
package scan_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_CHAINS = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SHIFT,
    ST_UPDATE
  } scan_state_e;

  // One-hot style control bundle broadcast from the sequencer to every chain.
  // func overrides the others: in functional mode the chains only pass data.
  typedef struct packed {
    logic func;
    logic capture;
    logic shift;
    logic update;
  } chain_ctrl_t;

endpackage

// File: rtl/scannable_chain_param_if.sv
// Scan-control and data bundle between a driving agent (master) and the scan
// block (slave). The block itself exposes the same names as discrete ports.
interface scannable_chain_param_if #(
  parameter int WIDTH  = scan_pkg::DEF_WIDTH,
  parameter int CHAINS = scan_pkg::DEF_CHAINS
);
  logic                    TST;
  logic                    Start;
  logic [CHAINS-1:0]       TDI;
  logic [CHAINS*WIDTH-1:0] Data_in;
  logic [CHAINS-1:0]       TDO;
  logic [CHAINS*WIDTH-1:0] Data_out;
  logic                    Busy;
  logic                    Done;

  modport master (
    output TST, Start, TDI, Data_in,
    input  TDO, Data_out, Busy, Done
  );

  modport slave (
    input  TST, Start, TDI, Data_in,
    output TDO, Data_out, Busy, Done
  );
endinterface

// File: rtl/scan_cell_chain.sv
// One WIDTH-bit scan chain: capture/shift register plus registered parallel
// update stage. Sequencing is decided by the parent; this cell only obeys ctrl.
module scan_cell_chain
  import scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  chain_ctrl_t       ctrl,
  input  logic              tdi,
  input  logic [WIDTH-1:0]  pin,
  output logic              tdo,
  output logic [WIDTH-1:0]  pout
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] pout_q, pout_d;

  // Next-state for the shift register and the parallel output stage.
  always_comb begin
    sr_d   = sr_q;
    pout_d = pout_q;
    if (ctrl.func) begin
      pout_d = pin;
    end else begin
      if (ctrl.capture) begin
        sr_d = pin;
      end else if (ctrl.shift) begin
        sr_d = {sr_q[WIDTH-2:0], tdi};
      end
      if (ctrl.update) begin
        pout_d = sr_q;
      end
    end
  end

  // Register stage; synchronous reset clears both registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is reset (not left to power-up) because TDO
      // is observed directly and must read 0 straight after reset.
      sr_q   <= '0;
      pout_q <= '0;
    end else begin
      sr_q   <= sr_d;
      pout_q <= pout_d;
    end
  end

  assign tdo  = sr_q[WIDTH-1];
  assign pout = pout_q;

endmodule

// File: rtl/scannable_chain_param.sv
// Parameterised multi-chain scan block: one capture/shift/update sequencer
// driving CHAINS identical scan_cell_chain instances in lock-step.
module scannable_chain_param
  import scan_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CHAINS = DEF_CHAINS
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic                    TST,
  input  logic                    Start,
  input  logic [CHAINS-1:0]       TDI,
  input  logic [CHAINS*WIDTH-1:0] Data_in,
  output logic [CHAINS-1:0]       TDO,
  output logic [CHAINS*WIDTH-1:0] Data_out,
  output logic                    Busy,
  output logic                    Done
);

  localparam int               CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  chain_ctrl_t      ctrl;

  // Sequencer next-state and chain controls; dropping TST aborts at once.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ctrl    = '0;
    if (!TST) begin
      state_d   = ST_IDLE;
      ctrl.func = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          ctrl.capture = 1'b1;
          cnt_d        = '0;
          state_d      = ST_SHIFT;
        end
        ST_SHIFT: begin
          ctrl.shift = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_SHIFT) state_d = ST_UPDATE;
        end
        ST_UPDATE: begin
          ctrl.update = 1'b1;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer state register; RESET wins over everything else.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all flops update
    // together from pre-edge values; the comb block above uses blocking.
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  for (genvar c = 0; c < CHAINS; c++) begin : g_chain
    scan_cell_chain #(
      .WIDTH (WIDTH)
    ) u_chain (
      .clk  (clk),
      .rst  (RESET),
      .ctrl (ctrl),
      .tdi  (TDI[c]),
      .pin  (Data_in[c*WIDTH +: WIDTH]),
      .tdo  (TDO[c]),
      .pout (Data_out[c*WIDTH +: WIDTH])
    );
  end

  assign Busy = (state_q != ST_IDLE);
  assign Done = done_q;

endmodule

// File: tb/tb_scannable_chain_param.sv
// Bench for scannable_chain_param (WIDTH=4, CHAINS=2): directed scenarios plus
// randomized traffic, with a cycle-level scoreboard fed by a reference model.
module tb_scannable_chain_param;

  localparam int W  = 4;
  localparam int C  = 2;
  localparam int DW = W * C;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scannable_chain_param_if #(.WIDTH(W), .CHAINS(C)) bus ();

  scannable_chain_param #(.WIDTH(W), .CHAINS(C)) dut (
    .clk      (clk),
    .RESET    (rst),
    .TST      (bus.TST),
    .Start    (bus.Start),
    .TDI      (bus.TDI),
    .Data_in  (bus.Data_in),
    .TDO      (bus.TDO),
    .Data_out (bus.Data_out),
    .Busy     (bus.Busy),
    .Done     (bus.Done)
  );

  typedef struct {
    logic [DW-1:0] dout;
    logic [C-1:0]  tdo;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: sequence age in edges since Start was accepted
  // (-1 = idle), chain contents as plain integers.
  int            m_age = -1;
  int            m_sr[C];
  logic [DW-1:0] m_dout;
  logic          m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic t, input logic s,
                            input logic [C-1:0] ti, input logic [DW-1:0] di);
    if (r) begin
      m_age = -1;
      for (int c = 0; c < C; c++) m_sr[c] = 0;
      m_dout = '0;
      m_done = 1'b0;
    end else if (!t) begin
      m_age  = -1;
      m_dout = di;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_age < 0) begin
        if (s) m_age = 0;
      end else if (m_age == 0) begin
        for (int c = 0; c < C; c++) m_sr[c] = int'(di[c*W +: W]);
        m_age = 1;
      end else if (m_age <= W) begin
        for (int c = 0; c < C; c++) m_sr[c] = (m_sr[c] * 2 + int'(ti[c])) % (1 << W);
        m_age++;
      end else begin
        for (int c = 0; c < C; c++) m_dout[c*W +: W] = W'(m_sr[c]);
        m_done = 1'b1;
        m_age  = -1;
      end
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, advance a clock.
  task automatic step(input logic r, input logic t, input logic s,
                      input logic [C-1:0] ti, input logic [DW-1:0] di);
    exp_t e;
    rst         = r;
    bus.TST     = t;
    bus.Start   = s;
    bus.TDI     = ti;
    bus.Data_in = di;
    model_edge(r, t, s, ti, di);
    e.dout = m_dout;
    for (int c = 0; c < C; c++) e.tdo[c] = ((m_sr[c] >> (W - 1)) & 1) != 0;
    e.busy = (m_age >= 0);
    e.done = m_done;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle's outputs are compared against the predicted entry.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sb_data_out", 32'(bus.Data_out), 32'(e.dout));
      check("sb_tdo",      32'(bus.TDO),      32'(e.tdo));
      check("sb_busy",     32'(bus.Busy),     32'(e.busy));
      check("sb_done",     32'(bus.Done),     32'(e.done));
    end
  end

  initial begin
    logic [C-1:0] tdo_exp [4];
    int           n_done;
    tdo_exp = '{2'b10, 2'b10, 2'b01, 2'b00};

    // Initial reset.
    step(1, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    check("rst_data_out", 32'(bus.Data_out), 32'h00);
    check("rst_tdo",      32'(bus.TDO),      32'h0);
    check("rst_busy",     32'(bus.Busy),     32'h0);
    check("rst_done",     32'(bus.Done),     32'h0);

    // Functional mode: pass-through, Start ignored.
    step(0, 0, 0, 2'b00, 8'hC2);
    check("func_data_out", 32'(bus.Data_out), 32'hC2);
    step(0, 0, 1, 2'b00, 8'hC2);
    check("func_start_busy", 32'(bus.Busy), 32'h0);
    step(0, 0, 0, 2'b00, 8'hC2);
    check("func_start_busy2", 32'(bus.Busy), 32'h0);

    // Full scan sequence.
    step(0, 1, 1, 2'b01, 8'hC2);
    check("scan_busy_after_start", 32'(bus.Busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 2'b01, 8'hC2);
      check($sformatf("scan_tdo_%0d", i), 32'(bus.TDO), 32'(tdo_exp[i]));
    end
    step(0, 1, 0, 2'b01, 8'hC2);
    check("scan_done_early",   32'(bus.Done),     32'h0);
    check("scan_hold_dout",    32'(bus.Data_out), 32'hC2);
    step(0, 1, 0, 2'b01, 8'hC2);
    check("scan_done",         32'(bus.Done),     32'h1);
    check("scan_data_out",     32'(bus.Data_out), 32'h0F);
    step(0, 1, 0, 2'b01, 8'hC2);
    check("scan_done_one_cyc", 32'(bus.Done),     32'h0);
    check("scan_idle",         32'(bus.Busy),     32'h0);

    // Back-to-back Start while busy: exactly one Done.
    n_done = 0;
    step(0, 1, 1, 2'b11, 8'h96);
    for (int i = 1; i < 10; i++) begin
      step(0, 1, (i == 2 || i == 3), 2'b11, 8'h96);
      if (bus.Done) n_done++;
    end
    check("b2b_done_count", 32'(n_done), 32'd1);

    // Abort after two shifts by dropping TST.
    step(0, 1, 1, 2'b10, 8'hA5);
    step(0, 1, 0, 2'b10, 8'hA5);
    step(0, 1, 0, 2'b10, 8'hA5);
    step(0, 1, 0, 2'b10, 8'hA5);
    step(0, 0, 0, 2'b10, 8'h5A);
    check("abort_busy",     32'(bus.Busy),     32'h0);
    check("abort_done",     32'(bus.Done),     32'h0);
    check("abort_data_out", 32'(bus.Data_out), 32'h5A);
    step(0, 0, 0, 2'b10, 8'h5A);
    check("abort_done2",    32'(bus.Done),     32'h0);

    // Reset during SHIFT, then a clean sequence.
    step(0, 1, 1, 2'b10, 8'h3C);
    step(0, 1, 0, 2'b10, 8'h3C);
    step(0, 1, 0, 2'b10, 8'h3C);
    step(1, 1, 0, 2'b10, 8'h3C);
    check("midrst_data_out", 32'(bus.Data_out), 32'h00);
    check("midrst_tdo",      32'(bus.TDO),      32'h0);
    check("midrst_busy",     32'(bus.Busy),     32'h0);
    check("midrst_done",     32'(bus.Done),     32'h0);
    step(0, 1, 1, 2'b10, 8'h3C);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 2'b10, 8'h3C);
    check("midrst_done_early", 32'(bus.Done),     32'h0);
    step(0, 1, 0, 2'b10, 8'h3C);
    check("midrst_seq_done",   32'(bus.Done),     32'h1);
    check("midrst_seq_dout",   32'(bus.Data_out), 32'hF0);

    // Randomized traffic checked by the scoreboard.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(63) == 0, $urandom_range(7) != 0, $urandom_range(3) == 0,
           C'($urandom), DW'($urandom));
    end

    // Reset for two edges in the middle of traffic.
    step(0, 1, 1, 2'b01, 8'hE7);
    step(0, 1, 0, 2'b01, 8'hE7);
    step(0, 1, 0, 2'b01, 8'hE7);
    step(1, 1, 1, 2'b01, 8'hE7);
    step(1, 1, 1, 2'b01, 8'hE7);
    check("rst2_data_out", 32'(bus.Data_out), 32'h00);
    check("rst2_tdo",      32'(bus.TDO),      32'h0);
    check("rst2_busy",     32'(bus.Busy),     32'h0);
    check("rst2_done",     32'(bus.Done),     32'h0);

    @(negedge clk);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
